// File: rtl/xkbd_rx.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 clock and data lines,
// deframes 11-bit frames (start, 8 data LSB first, odd parity, stop), and
// queues good scancodes in a small FIFO that the controller pops with sel.
// Sticky err flags: bit0 frame/parity/timeout error, bit1 FIFO overflow.
// Optional build macro PS2_BREAK_FILTER_EN drops 0xF0 and the byte after it.
module xkbd_rx #(
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       sel,
  input  logic       clr,
  output logic [8:0] data_out,
  output logic [1:0] err
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned CntW  = FIFO_AW + 1;
  localparam int unsigned WdW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e state_q, state_d;

  logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
  logic ps2_data_s1_q, ps2_data_s2_q;
  logic fall;

  logic [2:0]     bit_cnt_q;
  logic [7:0]     code_q;
  logic           parity_q;
  logic [WdW-1:0] wd_q;

  logic timeout, par_good, push_req, frame_err, byte_push;
  logic push_q;
  logic [7:0] push_data_q;

  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]    cnt_q;
  logic               empty, full, pop, wr_en, overflow;
  logic [1:0]         err_q;

  // Two-flop synchronizers plus a delayed copy of the clock for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ps2_clk_s1_q   <= 1'b1;
      ps2_clk_s2_q   <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_data_s1_q  <= 1'b1;
      ps2_data_s2_q  <= 1'b1;
    end else begin
      ps2_clk_s1_q   <= ps2_clk;
      ps2_clk_s2_q   <= ps2_clk_s1_q;
      ps2_clk_prev_q <= ps2_clk_s2_q;
      ps2_data_s1_q  <= ps2_data;
      ps2_data_s2_q  <= ps2_data_s1_q;
    end
  end

  assign fall     = ps2_clk_prev_q & ~ps2_clk_s2_q;
  assign par_good = ^{code_q, parity_q};

  // Deframer state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic: advance only on falling edges; watchdog aborts a stalled frame.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = StIdle;
    end else if (fall) begin
      unique case (state_q)
        StIdle:   if (!ps2_data_s2_q) state_d = StData;
        StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: push request and error strobe.
  always_comb begin
    timeout   = (state_q != StIdle) && !fall && (wd_q == WdMax);
    push_req  = 1'b0;
    frame_err = timeout;
    if (fall && state_q == StIdle && ps2_data_s2_q) frame_err = 1'b1;
    if (fall && state_q == StStop) begin
      if (ps2_data_s2_q && par_good) push_req  = 1'b1;
      else                           frame_err = 1'b1;
    end
  end

  // Frame datapath: bit counter, shift register, parity capture, watchdog.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt_q   <= '0;
      code_q      <= '0;
      parity_q    <= 1'b0;
      wd_q        <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      if (fall || state_q == StIdle) wd_q <= '0;
      else                           wd_q <= wd_q + 1'b1;
      if (timeout) begin
        code_q    <= '0;
        bit_cnt_q <= '0;
      end else if (fall) begin
        unique case (state_q)
          StIdle: bit_cnt_q <= '0;
          StData: begin
            code_q    <= {ps2_data_s2_q, code_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          StParity: parity_q <= ps2_data_s2_q;
          default: ;
        endcase
      end
      // Registered push lands in the FIFO the cycle after the stop edge.
      push_q      <= byte_push;
      push_data_q <= code_q;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic skip_q;

  // Break filter: swallow 0xF0 and the key code that follows it.
  always_comb begin
    byte_push = push_req && !skip_q && (code_q != 8'hF0);
  end

  // Skip flag: set by a break prefix, consumed by the next good byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      skip_q <= 1'b0;
    end else if (push_req) begin
      skip_q <= skip_q ? 1'b0 : (code_q == 8'hF0);
    end
  end
`else
  // Every good byte is queued.
  always_comb begin
    byte_push = push_req;
  end
`endif

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(Depth));
  assign pop      = sel && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en    = push_q && (!full || pop);
  assign overflow = push_q && full && !pop;

  // FIFO storage; no reset needed since data_out masks it while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= push_data_q;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      if (wr_en && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!wr_en && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Sticky error flags; a new set in the same cycle overrides clr.
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 2'b00;
    else      err_q <= {overflow, frame_err} | (err_q & ~{2{clr}});
  end

  // Head-of-FIFO view for the controller.
  always_comb begin
    data_out = {!empty, empty ? 8'h00 : mem_q[rptr_q]};
  end

  assign err = err_q;

endmodule

// File: tb/tb_xkbd_rx.sv
// Scoreboard bench for xkbd_rx: the stimulus thread queues expected scancodes,
// the monitor thread compares data_out against the queue on every sel pop.
module tb_xkbd_rx;

  localparam int unsigned Tmo = 300;
  localparam int unsigned H   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       sel;
  logic       clr;
  logic [8:0] data_out;
  logic [1:0] err;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];

  xkbd_rx #(
    .FIFO_AW    (3),
    .TIMEOUT_CYC(Tmo)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .sel     (sel),
    .clr     (clr),
    .data_out(data_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One PS/2 bit; optionally pulse sel so the pop meets the push this edge causes.
  task automatic ps2_bit(input logic b, input bit pop_at_fall);
    ps2_data = b;
    repeat (H) tick();
    ps2_clk = 1'b0;
    if (pop_at_fall) begin
      repeat (3) tick();
      sel = 1'b1;
      tick();
      sel = 1'b0;
      repeat (H - 4) tick();
    end else begin
      repeat (H) tick();
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit pop_at_stop);
    logic par;
    par = (~^code) ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(1'b1, pop_at_stop);
    ps2_data = 1'b1;
    repeat (4) tick();
  endtask

  task automatic partial_frame(input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(i[0], 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic pop_n(input int n);
    sel = 1'b1;
    repeat (n) tick();
    sel = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; sel = 1'b0; clr = 1'b0;
    fork
      begin : stim
        repeat (4) tick();
        check("reset_data_out", data_out, 9'h000);
        check("reset_err", {7'd0, err}, 9'd0);
        rst = 1'b1;
        repeat (4) tick();

        // Single good frame, then pop it.
        send_frame(8'h1C, 1'b0, 1'b0);
        check("frame_1c_head", data_out, 9'h11C);
        check("frame_1c_err", {7'd0, err}, 9'd0);
        exp_q.push_back(8'h1C);
        pop_n(1);
        check("after_pop_empty", data_out, 9'h000);

        // Bad parity: no push, err[0]; clr clears.
        send_frame(8'h1C, 1'b1, 1'b0);
        check("bad_parity_nopush", data_out, 9'h000);
        check("bad_parity_err", {7'd0, err}, 9'd1);
        pulse_clr();
        check("clr_err", {7'd0, err}, 9'd0);

        // Overflow: nine frames into an eight-entry FIFO.
        for (int i = 1; i <= 9; i++) begin
          send_frame(8'(i), 1'b0, 1'b0);
          if (i <= 8) exp_q.push_back(8'(i));
        end
        check("overflow_err", {7'd0, err}, 9'd2);
        pop_n(8);
        check("overflow_drained", data_out, 9'h000);
        pulse_clr();
        check("overflow_clr", {7'd0, err}, 9'd0);

        // Watchdog abort of a stalled frame, then a clean frame.
        partial_frame(4);
        repeat (Tmo + 30) tick();
        check("timeout_err", {7'd0, err}, 9'd1);
        check("timeout_nopush", data_out, 9'h000);
        pulse_clr();
        send_frame(8'h5A, 1'b0, 1'b0);
        check("after_timeout_head", data_out, 9'h15A);
        check("after_timeout_err", {7'd0, err}, 9'd0);
        exp_q.push_back(8'h5A);
        pop_n(1);

        // Full FIFO with a pop landing in the same cycle as a push.
        for (int i = 0; i < 8; i++) begin
          send_frame(8'h40 + 8'(i), 1'b0, 1'b0);
          exp_q.push_back(8'h40 + 8'(i));
        end
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b0, 1'b1);
        check("full_pushpop_err", {7'd0, err}, 9'd0);
        check("full_pushpop_head", data_out, 9'h141);
        pop_n(8);
        check("full_pushpop_drained", data_out, 9'h000);

        // Break prefix handling.
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
        exp_q.push_back(8'h32);
        check("break_head", data_out, 9'h132);
        pop_n(1);
`else
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1C);
        exp_q.push_back(8'h32);
        check("break_head", data_out, 9'h1F0);
        pop_n(3);
`endif
        check("break_drained", data_out, 9'h000);

        // Reset mid-frame discards the partial frame.
        partial_frame(3);
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        ps2_clk = 1'b1;
        repeat (4) tick();
        send_frame(8'h2B, 1'b0, 1'b0);
        check("post_reset_head", data_out, 9'h12B);
        check("post_reset_err", {7'd0, err}, 9'd0);
        exp_q.push_back(8'h2B);
        pop_n(1);
        check("final_empty", data_out, 9'h000);
        repeat (2) tick();
        check("scoreboard_empty", 9'(exp_q.size()), 9'd0);
      end
      begin : monitor
        logic [7:0] e;
        forever begin
          @(negedge clk);
          if (sel && data_out[8]) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL pop_unexpected: got %h expected nothing", data_out);
            end else begin
              e = exp_q.pop_front();
              check("pop_data", data_out, {1'b1, e});
            end
          end
        end
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/xkbd_rx.md
XKBD_RX -- requirements
Module: xkbd_rx

Interface
REQ-001 Parameter FIFO_AW, default 3, log2 of scancode FIFO depth (8 entries).
REQ-002 Parameter TIMEOUT_CYC, default 100000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
REQ-006 ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
REQ-007 sel  input  1  controller read strobe; one pop per cycle asserted.
REQ-008 clr  input  1  clears sticky error flags.
REQ-009 data_out  output  9  {fifo_nonempty, head scancode[7:0]}; combinational from FIFO head.
REQ-010 err  output  2  sticky flags: bit0 frame/parity error, bit1 FIFO overflow.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer; a falling edge is synchronized ps2_clk 1 -> 0 between consecutive synchronized samples.
REQ-012 FSM states IDLE, DATA, PARITY, STOP; all sampling occurs only on detected falling edges.
REQ-013 IDLE: on edge with data=0 -> DATA, bit counter 0; on edge with data=1 -> stay IDLE, set err[0].
REQ-014 DATA: shift data into code register LSB first; after 8th bit -> PARITY.
REQ-015 PARITY: capture bit; frame parity is good when XOR of 8 data bits and parity bit = 1 (odd); -> STOP.
REQ-016 STOP: if data=1 and parity good, push code (cycle after edge); otherwise set err[0], no push; -> IDLE in all cases.
REQ-017 Watchdog counter SHALL clear on every falling edge and in IDLE; in any other state reaching TIMEOUT_CYC-1 -> IDLE, set err[0], discard partial code.
REQ-018 FIFO: depth 2^FIFO_AW, read/write pointers wrap modulo depth, count width FIFO_AW+1.
REQ-019 Push while full: byte dropped, FIFO unchanged, err[1] set.
REQ-020 sel while empty: ignored, pointers unchanged, no error.
REQ-021 Simultaneous push and pop (including when full): both performed, count unchanged; pop while full frees a slot, so no overflow.
REQ-022 data_out[8] = (count != 0); data_out[7:0] = head entry, 0x00 when empty.
REQ-023 Latency: pushed byte visible on data_out no later than 2 clk after the stop-bit falling edge is detected.
REQ-024 clr clears err the same cycle; a concurrent set wins over clr.

Reset
REQ-025 With rst=0 at a rising edge: FSM IDLE, counters, pointers, code register, synchronizers (to 1), err=2'b00, data_out=9'h000.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first frame after release is received only from its start bit.

Configuration
REQ-027 Macro PS2_BREAK_FILTER_EN: when defined, a received 0xF0 is not pushed and sets a skip flag; the next valid byte is also not pushed and clears the flag; 0xE0 is pushed normally; the skip flag is cleared by reset.
REQ-028 Without PS2_BREAK_FILTER_EN every valid byte, including 0xF0, is pushed; no skip flag exists.

Verification
REQ-029 Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) -> data_out=9'h11C; one sel -> data_out=9'h000.
REQ-030 Frame 0x1C with parity bit 1 -> no push, err=2'b01; clr pulse -> err=2'b00.
REQ-031 Nine valid frames 0x01..0x09 without reads -> err[1]=1; eight pops return 0x01..0x08 in order, then data_out[8]=0.
REQ-032 Start bit then 4 data bits, then no edges for TIMEOUT_CYC cycles -> FSM IDLE, err[0]=1; next full frame 0x5A is received correctly.
REQ-033 FIFO full, stop edge of frame 0x33 in the same cycle as sel -> no overflow, count stays 8, 0x33 is the last entry read.
REQ-034 Byte sequence F0,1C,32: with PS2_BREAK_FILTER_EN -> only 0x32 read; without it -> 0xF0, 0x1C, 0x32 read in order.
